// File: rtl/ctrl_pkg.sv
// Shared definitions for the LEGv8 multi-cycle main controller.
//   - ctrl_state_e : controller state encoding
//   - instr_class_e: instruction class latched in DECODE
//   - OP_*         : fully specified opcode values (bits [31:21])
//   - ALUOP_*      : 2-bit ALUOp codes handed to the ALU control decoder
//   - COND_LT      : the only B.cond condition accepted when CTRL_BCOND_EN is defined
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } ctrl_state_e;

  typedef enum logic [2:0] {
    ClsRtype,
    ClsAddi,
    ClsLdur,
    ClsStur,
    ClsB,
    ClsCbz,
    ClsBcond,
    ClsIllegal
  } instr_class_e;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASS  = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [4:0] COND_LT = 5'b01011;

endpackage

// File: rtl/main_control_fsm_if.sv
// Memory handshake bundle between the main controller and the instruction/data memories.
//   imem_req/imem_ready : instruction fetch request and completion
//   dmem_req/dmem_we    : data access request and write strobe (stable while req is high)
//   dmem_ready          : data access completion
// Modports: master = controller side, slave = memory side.
interface main_control_fsm_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/opcode_class_decode.sv
// Combinational opcode (plus B.cond cond field) to instruction class decoder.
//   opcode  in  : instruction bits [31:21]
//   cond    in  : instruction bits [4:0]
//   cls     out : decoded instruction class
//   illegal out : opcode (or cond) not supported
// Macro CTRL_BCOND_EN: when defined, B.cond LT is legal; otherwise every B.cond is illegal.
module opcode_class_decode
  import ctrl_pkg::*;
(
  input  logic [10:0]  opcode,
  input  logic [4:0]   cond,
  output instr_class_e cls,
  output logic         illegal
);

  always_comb begin
    cls     = ClsIllegal;
    illegal = 1'b0;
    casez (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: cls = ClsRtype;
      11'b1001000100?:                cls = ClsAddi;
      OP_LDUR:                        cls = ClsLdur;
      OP_STUR:                        cls = ClsStur;
      11'b000101?????:                cls = ClsB;
      11'b10110100???:                cls = ClsCbz;
      11'b01010100???: begin
`ifdef CTRL_BCOND_EN
        cls     = ClsBcond;
        illegal = (cond != COND_LT);
`else
        illegal = 1'b1;
`endif
      end
      default:                        illegal = 1'b1;
    endcase
  end

`ifndef CTRL_BCOND_EN
  logic unused_cond;
  assign unused_cond = ^cond;
`endif

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle LEGv8 main controller: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Ports:
//   clk, reset (async, active-high)
//   opcode, cond          : instruction fields from the IR
//   alu_zero/neg/ovf      : ALU flags sampled in EXEC
//   mem                   : memory handshake interface (master modport)
//   ir_write, pc_write    : IR / PC load enables
//   alu_op, alu_src, reg2loc, mem_to_reg, reg_write, br_taken, uncond_br : datapath controls
//   trap                  : sticky illegal-opcode / memory-timeout indication
// Parameter MEM_TIMEOUT: cycles a request may wait for ready before TRAP (0 = no watchdog).
// Macro CTRL_BCOND_EN: enables B.cond LT support.
module main_control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [10:0]                opcode,
  input  logic [4:0]                 cond,
  input  logic                       alu_zero,
  input  logic                       alu_neg,
  input  logic                       alu_ovf,
  main_control_fsm_if.master         mem,
  output logic                       ir_write,
  output logic                       pc_write,
  output logic [1:0]                 alu_op,
  output logic                       alu_src,
  output logic                       reg2loc,
  output logic                       mem_to_reg,
  output logic                       reg_write,
  output logic                       br_taken,
  output logic                       uncond_br,
  output logic                       trap
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  ctrl_state_e     state_q, state_d;
  instr_class_e    cls_q, cls_d, dec_cls;
  logic            dec_illegal;
  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            waiting, timeout;
  logic            imem_req, dmem_req, dmem_we;

  opcode_class_decode u_decode (
    .opcode  (opcode),
    .cond    (cond),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  // Counter runs only while a request is outstanding; any other cycle (including the one
  // before entering FETCH/MEM) clears it. Ready on the limit cycle wins since waiting is 0.
  assign waiting  = ((state_q == StFetch) && !mem.imem_ready) ||
                    ((state_q == StMem)   && !mem.dmem_ready);
  assign wd_cnt_d = waiting ? wd_cnt_q + 1'b1 : '0;
  assign timeout  = (MEM_TIMEOUT != 0) && waiting && (wd_cnt_d == CntW'(MEM_TIMEOUT));

  assign mem.imem_req = imem_req;
  assign mem.dmem_req = dmem_req;
  assign mem.dmem_we  = dmem_we;

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_op     = ALUOP_ADD;
    alu_src    = 1'b0;
    reg2loc    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    br_taken   = 1'b0;
    uncond_br  = 1'b0;
    trap       = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_write = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StDecode: begin
        cls_d   = dec_cls;
        state_d = dec_illegal ? StTrap : StExec;
      end
      StExec: begin
        unique case (cls_q)
          ClsRtype: begin
            alu_op  = ALUOP_FUNCT;
            state_d = StWb;
          end
          ClsAddi: begin
            alu_op  = ALUOP_FUNCT;
            alu_src = 1'b1;
            state_d = StWb;
          end
          ClsLdur: begin
            alu_src = 1'b1;
            state_d = StMem;
          end
          ClsStur: begin
            alu_src = 1'b1;
            reg2loc = 1'b1;
            state_d = StMem;
          end
          ClsB: begin
            uncond_br = 1'b1;
            br_taken  = 1'b1;
            pc_write  = 1'b1;
            state_d   = StFetch;
          end
          ClsCbz: begin
            alu_op   = ALUOP_PASS;
            reg2loc  = 1'b1;
            br_taken = alu_zero;
            pc_write = 1'b1;
            state_d  = StFetch;
          end
          ClsBcond: begin
`ifdef CTRL_BCOND_EN
            alu_op   = ALUOP_PASS;
            br_taken = alu_neg ^ alu_ovf;  // signed less-than
            pc_write = 1'b1;
            state_d  = StFetch;
`else
            state_d  = StTrap;
`endif
          end
          ClsIllegal: state_d = StTrap;
        endcase
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == ClsStur);
        if (mem.dmem_ready) begin
          if (cls_q == ClsStur) begin
            pc_write = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d = StTrap;
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        mem_to_reg = (cls_q == ClsLdur);
        state_d    = StFetch;
      end
      StTrap: trap = 1'b1;
      default: state_d = StTrap;
    endcase
  end

`ifndef CTRL_BCOND_EN
  logic unused_flags;
  assign unused_flags = alu_neg ^ alu_ovf;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      cls_q    <= ClsIllegal;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm. Each step drives inputs, pushes the expected output
// vector to a scoreboard queue, and pops/compares it at the following falling edge.
// Output vector bit order:
//   imem_req dmem_req dmem_we ir_write pc_write alu_op[1:0] alu_src reg2loc mem_to_reg
//   reg_write br_taken uncond_br trap
module tb_main_control_fsm;

  localparam logic [13:0] V_FWAIT   = 14'b1_0_0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [13:0] V_FRDY    = 14'b1_0_0_1_0_00_0_0_0_0_0_0_0;
  localparam logic [13:0] V_IDLE    = 14'b0_0_0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [13:0] V_EX_R    = 14'b0_0_0_0_0_10_0_0_0_0_0_0_0;
  localparam logic [13:0] V_EX_ADDI = 14'b0_0_0_0_0_10_1_0_0_0_0_0_0;
  localparam logic [13:0] V_EX_LD   = 14'b0_0_0_0_0_00_1_0_0_0_0_0_0;
  localparam logic [13:0] V_EX_ST   = 14'b0_0_0_0_0_00_1_1_0_0_0_0_0;
  localparam logic [13:0] V_WB      = 14'b0_0_0_0_1_00_0_0_0_1_0_0_0;
  localparam logic [13:0] V_WB_LD   = 14'b0_0_0_0_1_00_0_0_1_1_0_0_0;
  localparam logic [13:0] V_MEM_LD  = 14'b0_1_0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [13:0] V_MEM_STW = 14'b0_1_1_0_0_00_0_0_0_0_0_0_0;
  localparam logic [13:0] V_MEM_STR = 14'b0_1_1_0_1_00_0_0_0_0_0_0_0;
  localparam logic [13:0] V_CBZ_T   = 14'b0_0_0_0_1_01_0_1_0_0_1_0_0;
  localparam logic [13:0] V_CBZ_N   = 14'b0_0_0_0_1_01_0_1_0_0_0_0_0;
  localparam logic [13:0] V_B       = 14'b0_0_0_0_1_00_0_0_0_0_1_1_0;
  localparam logic [13:0] V_TRAP    = 14'b0_0_0_0_0_00_0_0_0_0_0_0_1;
`ifdef CTRL_BCOND_EN
  localparam logic [13:0] V_BCOND_T = 14'b0_0_0_0_1_01_0_0_0_0_1_0_0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic [4:0]  cond;
  logic        alu_zero, alu_neg, alu_ovf;
  logic        ir_write, pc_write, alu_src, reg2loc, mem_to_reg, reg_write;
  logic        br_taken, uncond_br, trap;
  logic [1:0]  alu_op;
  logic [13:0] outs;

  main_control_fsm_if mif ();

  main_control_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .cond       (cond),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .alu_ovf    (alu_ovf),
    .mem        (mif),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .reg2loc    (reg2loc),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .br_taken   (br_taken),
    .uncond_br  (uncond_br),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  assign outs = {mif.imem_req, mif.dmem_req, mif.dmem_we, ir_write, pc_write, alu_op, alu_src,
                 reg2loc, mem_to_reg, reg_write, br_taken, uncond_br, trap};

  typedef struct {
    string       tag;
    logic [13:0] exp;
  } sb_t;

  sb_t sb[$];
  int  npass = 0;
  int  ntotal = 0;
  int  nfail = 0;

  task automatic push_exp(input string tag, input logic [13:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_front();
    sb_t         e;
    logic [13:0] obs;
    obs = outs;
    ntotal++;
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL scoreboard_empty: got %b required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) npass++;
      else begin
        nfail++;
        $error("FAIL %s: got %b required %b", e.tag, obs, e.exp);
      end
    end
  endtask

  // One clock cycle: drive ready inputs, check outputs at the falling edge.
  task automatic step(input string tag, input logic irdy, input logic drdy,
                      input logic [13:0] exp);
    mif.imem_ready = irdy;
    mif.dmem_ready = drdy;
    push_exp(tag, exp);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10:0] rops [4];
    rops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    opcode   = 11'b10001011000;
    cond     = 5'b00000;
    alu_zero = 1'b0;
    alu_neg  = 1'b0;
    alu_ovf  = 1'b0;
    do_reset();

    // R-type: F D E W, ready pulses outside a request must be ignored.
    for (int i = 0; i < 4; i++) begin
      opcode = rops[i];
      step("r_fetch", 1'b1, 1'b0, V_FRDY);
      step("r_decode", 1'b1, 1'b1, V_IDLE);
      step("r_exec", 1'b0, 1'b1, V_EX_R);
      step("r_wb", 1'b0, 1'b0, V_WB);
    end

    // ADDI
    opcode = 11'b10010001001;
    step("addi_fetch", 1'b1, 1'b0, V_FRDY);
    step("addi_decode", 1'b0, 1'b0, V_IDLE);
    step("addi_exec", 1'b0, 1'b0, V_EX_ADDI);
    step("addi_wb", 1'b0, 1'b0, V_WB);

    // LDUR, dmem_ready three cycles late
    opcode = 11'b11111000010;
    step("ldur_fetch", 1'b1, 1'b0, V_FRDY);
    step("ldur_decode", 1'b0, 1'b0, V_IDLE);
    step("ldur_exec", 1'b0, 1'b0, V_EX_LD);
    for (int i = 0; i < 3; i++) step("ldur_mem_wait", 1'b0, 1'b0, V_MEM_LD);
    step("ldur_mem_rdy", 1'b0, 1'b1, V_MEM_LD);
    step("ldur_wb", 1'b0, 1'b0, V_WB_LD);

    // STUR, zero wait
    opcode = 11'b11111000000;
    step("stur_fetch", 1'b1, 1'b0, V_FRDY);
    step("stur_decode", 1'b0, 1'b0, V_IDLE);
    step("stur_exec", 1'b0, 1'b0, V_EX_ST);
    step("stur_mem_rdy", 1'b0, 1'b1, V_MEM_STR);

    // CBZ taken then not taken
    opcode = 11'b10110100111;
    alu_zero = 1'b1;
    step("cbz1_fetch", 1'b1, 1'b1, V_FRDY);
    step("cbz1_decode", 1'b0, 1'b0, V_IDLE);
    step("cbz1_exec", 1'b0, 1'b0, V_CBZ_T);
    alu_zero = 1'b0;
    step("cbz0_fetch", 1'b1, 1'b0, V_FRDY);
    step("cbz0_decode", 1'b0, 1'b0, V_IDLE);
    step("cbz0_exec", 1'b0, 1'b0, V_CBZ_N);

    // Unconditional B
    opcode = 11'b00010110101;
    step("b_fetch", 1'b1, 1'b0, V_FRDY);
    step("b_decode", 1'b0, 1'b0, V_IDLE);
    step("b_exec", 1'b0, 1'b0, V_B);

    // B.cond LT with neg=1, ovf=0
    opcode  = 11'b01010100000;
    cond    = 5'b01011;
    alu_neg = 1'b1;
    step("bcond_fetch", 1'b1, 1'b0, V_FRDY);
    step("bcond_decode", 1'b0, 1'b0, V_IDLE);
`ifdef CTRL_BCOND_EN
    step("bcond_exec", 1'b0, 1'b0, V_BCOND_T);
    // Non-LT cond is illegal even with the feature enabled
    cond = 5'b00000;
    step("bcond_eq_fetch", 1'b1, 1'b0, V_FRDY);
    step("bcond_eq_decode", 1'b0, 1'b0, V_IDLE);
    step("bcond_eq_trap", 1'b0, 1'b0, V_TRAP);
`else
    step("bcond_trap", 1'b0, 1'b0, V_TRAP);
`endif
    alu_neg = 1'b0;
    do_reset();

    // Illegal opcode: trap is sticky whatever the handshakes do
    opcode = 11'b00000000000;
    step("ill_fetch", 1'b1, 1'b0, V_FRDY);
    step("ill_decode", 1'b0, 1'b0, V_IDLE);
    for (int i = 0; i < 4; i++) step("ill_trap", i[0], ~i[0], V_TRAP);
    do_reset();
    step("post_reset", 1'b0, 1'b0, V_FWAIT);
    do_reset();

    // Fetch watchdog: 16 waiting cycles then TRAP
    for (int i = 0; i < 16; i++) step("wd_fetch_wait", 1'b0, 1'b0, V_FWAIT);
    step("wd_fetch_trap", 1'b0, 1'b0, V_TRAP);
    step("wd_fetch_sticky", 1'b1, 1'b0, V_TRAP);
    do_reset();

    // Ready on the limit cycle wins over the timeout
    opcode = 11'b10001011000;
    for (int i = 0; i < 15; i++) step("wd_edge_wait", 1'b0, 1'b0, V_FWAIT);
    step("wd_edge_rdy", 1'b1, 1'b0, V_FRDY);
    step("wd_edge_decode", 1'b0, 1'b0, V_IDLE);
    do_reset();

    // Data watchdog on a LDUR that never completes
    opcode = 11'b11111000010;
    step("wdd_fetch", 1'b1, 1'b0, V_FRDY);
    step("wdd_decode", 1'b0, 1'b0, V_IDLE);
    step("wdd_exec", 1'b0, 1'b0, V_EX_LD);
    for (int i = 0; i < 16; i++) step("wdd_mem_wait", 1'b0, 1'b0, V_MEM_LD);
    step("wdd_trap", 1'b0, 1'b0, V_TRAP);
    do_reset();

    // Reset mid-MEM drops dmem_req asynchronously
    opcode = 11'b11111000000;
    step("rst_fetch", 1'b1, 1'b0, V_FRDY);
    step("rst_decode", 1'b0, 1'b0, V_IDLE);
    step("rst_exec", 1'b0, 1'b0, V_EX_ST);
    step("rst_mem_wait", 1'b0, 1'b0, V_MEM_STW);
    reset = 1'b1;
    #1;
    push_exp("rst_async_drop", V_FWAIT);
    check_front();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("rst_refetch", 1'b1, 1'b0, V_FRDY);
    step("rst_redecode", 1'b0, 1'b0, V_IDLE);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
